// File: rtl/memory_burst.sv
// memory_burst: single-port synchronous RAM with a valid/ready command
// interface, incrementing bursts of up to MAX_BURST beats, per-byte write
// strobes and a read-data valid/last return channel. Addresses wrap
// modulo DEPTH.
module memory_burst #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int MAX_BURST  = 8,
  parameter int BLEN_WIDTH = $clog2(MAX_BURST)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [BLEN_WIDTH-1:0] blen,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH/8-1:0]    wstrb,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic                  rlast
);

  localparam int NBYTES = WIDTH / 8;

  // S_RDONE is the single ready-low cycle after the last read beat.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RDONE = 2'd3
  } state_t;

  // Merge new_w into old_w wherever the byte strobe is set.
  function automatic logic [WIDTH-1:0] merge_bytes(
    input logic [WIDTH-1:0]  old_w,
    input logic [WIDTH-1:0]  new_w,
    input logic [NBYTES-1:0] strb
  );
    logic [WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NBYTES; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [WIDTH-1:0]      mem [DEPTH];

  state_t                state_q,  state_d;
  logic [BLEN_WIDTH-1:0] beat_q,   beat_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [BLEN_WIDTH-1:0] blen_q,   blen_d;
  logic                  ready_q,  ready_d;
  logic [WIDTH-1:0]      rdata_q,  rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q,  rlast_d;

  logic                  we_s;
  logic [ADDR_WIDTH-1:0] waddr_s;
  logic [ADDR_WIDTH-1:0] beat_addr_s;

  // Next-state, beat bookkeeping, write enable and read-return computation.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    blen_d      = blen_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    rlast_d     = 1'b0;
    we_s        = 1'b0;
    beat_addr_s = addr_q + ADDR_WIDTH'(beat_q);
    waddr_s     = beat_addr_s;

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          addr_d = addr;
          blen_d = blen;
          if (wr_rd) begin
            // The command cycle doubles as write beat 0.
            we_s    = 1'b1;
            waddr_s = addr;
            if (blen != {BLEN_WIDTH{1'b0}}) begin
              state_d = S_WRITE;
              beat_d  = BLEN_WIDTH'(1);
            end else begin
              state_d = S_IDLE;
              beat_d  = {BLEN_WIDTH{1'b0}};
            end
          end else begin
            state_d = S_READ;
            beat_d  = {BLEN_WIDTH{1'b0}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WRITE: begin
        if (valid) begin
          we_s = 1'b1;
          if (beat_q == blen_q) begin
            state_d = S_IDLE;
            beat_d  = {BLEN_WIDTH{1'b0}};
          end else begin
            state_d = S_WRITE;
            beat_d  = beat_q + BLEN_WIDTH'(1);
          end
        end else begin
          state_d = S_WRITE;
        end
      end

      S_READ: begin
        rvalid_d = 1'b1;
        rdata_d  = mem[beat_addr_s];
        rlast_d  = (beat_q == blen_q);
        if (beat_q == blen_q) begin
          state_d = S_RDONE;
          beat_d  = {BLEN_WIDTH{1'b0}};
        end else begin
          state_d = S_READ;
          beat_d  = beat_q + BLEN_WIDTH'(1);
        end
      end

      S_RDONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        beat_d  = {BLEN_WIDTH{1'b0}};
      end
    endcase

    ready_d = (state_d == S_IDLE) || (state_d == S_WRITE);
  end

  // Control and output registers; async reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      beat_q   <= {BLEN_WIDTH{1'b0}};
      addr_q   <= {ADDR_WIDTH{1'b0}};
      blen_q   <= {BLEN_WIDTH{1'b0}};
      ready_q  <= 1'b1;
      rdata_q  <= {WIDTH{1'b0}};
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      addr_q   <= addr_d;
      blen_q   <= blen_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
    end
  end

  // Storage array: never cleared, and no write lands while reset is held.
  always_ff @(posedge clk) begin
    if (we_s && rst) begin
      mem[waddr_s] <= merge_bytes(mem[waddr_s], wdata, wstrb);
    end
  end

  assign ready  = ready_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign rlast  = rlast_q;

endmodule

// File: doc/memory_burst.md
Name: memory_burst

Overview:
- Parametrised successor to the single-beat `memory` block: a single-port synchronous RAM with a valid/ready command interface.
- Adds incrementing bursts of up to MAX_BURST beats, per-byte write strobes, a read-data valid/last channel, and address wrap-around modulo DEPTH.
- Sits behind bus masters and testbench drivers wherever `memory` is used today; handshake semantics are unchanged for single-beat traffic.

Parameters:
- WIDTH, 16, data width in bits; must be a multiple of 8.
- DEPTH, 64, number of words.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- MAX_BURST, 8, maximum beats per burst.
- BLEN_WIDTH, $clog2(MAX_BURST), width of the burst-length field.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- valid  input  1  request/beat valid from master.
- wr_rd  input  1  1 = write burst, 0 = read burst; sampled at command accept only.
- addr  input  ADDR_WIDTH  start word address; sampled at command accept only.
- blen  input  BLEN_WIDTH  beats minus one (0 = single beat); sampled at command accept only.
- wdata  input  WIDTH  write data for the current beat.
- wstrb  input  WIDTH/8  byte enables for the current write beat; bit i covers wdata[8i+7:8i].
- ready  output  1  block accepts the command/beat this cycle.
- rdata  output  WIDTH  read data.
- rvalid  output  1  rdata valid this cycle.
- rlast  output  1  final read beat of the burst (only with rvalid).

Behaviour:
- Reset (rst=0, async): state=IDLE, ready=1, rvalid=0, rlast=0, rdata=0, beat counter=0. Memory contents are not cleared and are retained across reset.
- States:
  - IDLE: ready=1. On valid&&ready, latch wr_rd, addr, blen.
  - IDLE, write command: the command cycle is also beat 0. mem[addr] is updated with wdata under wstrb at that edge. If blen=0, stay in IDLE; else go to WRITE with beat=1.
  - IDLE, read command: go to READ with beat=0.
  - WRITE: ready=1. Each valid&&ready cycle writes beat n to mem[(addr+n) mod DEPTH] under wstrb, then beat++. valid=0 stalls with no write and no advance. After beat blen is written, go to IDLE; ready stays 1 throughout.
  - READ: ready=0. One beat per cycle with no backpressure and no stall. rvalid=1 and rdata=mem[(addr+n) mod DEPTH] from the cycle after command accept, for blen+1 consecutive cycles. rlast=1 on beat blen only. Return to IDLE the cycle after the last beat.
- Latency: command accepted at edge T → first read beat visible after edge T+1; last read beat after edge T+1+blen; ready returns high after edge T+2+blen. Write beat n is readable by any command accepted after its write edge.
- Addressing: address arithmetic is ADDR_WIDTH-wide and wraps modulo DEPTH (DEPTH is a power of two). Example: addr=62, blen=3 touches 62, 63, 0, 1.
- Byte strobes: wstrb=0 on a beat still consumes the beat and advances the counter; memory is unchanged.
- Input handling:
  - wr_rd, addr and blen are ignored during WRITE/READ.
  - valid during READ is ignored; ready=0 tells the master to hold.
  - In the READ return-to-IDLE cycle, ready=0; a new command is accepted only once ready=1.
- blen > MAX_BURST-1 cannot be encoded (BLEN_WIDTH bits); no error path exists.
- Reset mid-burst: abort immediately to the IDLE/reset values above. Beats written before reset remain in memory; unwritten beats are untouched. No read beat is output after reset asserts.

Test Plan:
- Single write/read: write addr=5, blen=0, wdata=16'hA5C3, wstrb=2'b11; then read addr=5, blen=0 → one rvalid cycle with rdata=16'hA5C3, rlast=1, ready low exactly 2 cycles.
- Burst with wrap: write addr=62, blen=3, data 1,2,3,4 (valid held); read addr=62, blen=3 → rdata 1,2,3,4 on 4 consecutive rvalid cycles, rlast on the 4th; mem[0]=3, mem[1]=4.
- Stall and strobes: write addr=10, blen=1 with valid dropped 2 cycles between beats, beat 1 wstrb=2'b01, wdata=16'hFFFF over prior 16'h1234 → read returns beat 0 data, then 16'h12FF.
- Full-depth sweep: write all 64 words with random data, in 8-beat bursts, back-to-back commands; read all back in 8-beat bursts → every word matches; ready never high during READ.
- Reset mid-burst: write addr=20, blen=7, assert rst after beat 3 → ready=1, rvalid=0 immediately. Re-read 20..27 → beats 0–3 new, 4–7 unchanged. Reset during READ beat 2 → rvalid drops the same cycle.
- Ignored inputs: toggle addr/blen/wr_rd and hold valid during a READ burst → burst output unaffected, no writes occur.
